// File: rtl/sdram_refresh_sched.sv
// sdram_refresh_sched
// Refresh scheduler and strobe gate in front of the 3-port SDRAM controller.
// Counts refresh debt from a free-running interval timer, issues refreshes
// opportunistically when the client channels have been quiet for three
// slots, and forces a drained batch when debt reaches URGENT_LEVEL. While a
// batch is running, new rising client strobes are held back so the
// controller never sees a channel edge competing with a refresh.
//
// Ports:
//   clk               controller state-machine clock
//   init_n            synchronous active-low reset
//   rd_in[2:0]        client read strobes {C,B,A} (level, rising edge = request)
//   wr_in[2:0]        client write strobes {C,B,A}
//   rd_out[2:0]       gated read strobes to controller oeC/oeB/oeA
//   wr_out[2:0]       gated write strobes to controller weC/weB/weA
//   refresh           refresh level to the controller (high for one slot)
//   mask              high while rising strobes are being deferred
//   debt[3:0]         refreshes owed
//   overflow          sticky: a tick arrived while debt was saturated
module sdram_refresh_sched #(
  parameter int REFI_CYCLES  = 663,
  parameter int SLOT_CYCLES  = 8,
  parameter int DEBT_MAX     = 8,
  parameter int URGENT_LEVEL = 6
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic [2:0] rd_in,
  input  logic [2:0] wr_in,
  output logic [2:0] rd_out,
  output logic [2:0] wr_out,
  output logic       refresh,
  output logic       mask,
  output logic [3:0] debt,
  output logic       overflow
);

  localparam int TW       = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;
  localparam int IDLE_MAX = 3 * SLOT_CYCLES;
  localparam int IW       = $clog2(IDLE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REF} state_t;

  state_t          state, state_nx;
  logic            forced, forced_nx;
  logic [IW-1:0]   phase, phase_nx;
  logic [TW-1:0]   timer;
  logic [IW-1:0]   idle_cnt;
  logic [2:0]      strobe_q;
  logic [2:0]      rd_hold, wr_hold;
  logic [3:0]      debt_nx;
  logic            ovf_nx;
  logic            tick, done, rise;

  // ---------------------------------------------------------------- timer
  assign tick = (timer == TW'(REFI_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!init_n)   timer <= '0;
    else if (tick) timer <= '0;
    else           timer <= timer + 1'b1;
  end

  // --------------------------------------------------------- idle counter
  assign rise = |((rd_in | wr_in) & ~strobe_q);

  always_ff @(posedge clk) begin
    if (!init_n) begin
      strobe_q <= '0;
      idle_cnt <= '0;
    end else begin
      strobe_q <= rd_in | wr_in;
      if (rise)                          idle_cnt <= '0;
      else if (idle_cnt != IW'(IDLE_MAX)) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // ------------------------------------------------------------------ debt
  assign done = (state == S_REF) && (phase == IW'(SLOT_CYCLES - 1));

  always_comb begin
    debt_nx = debt;
    ovf_nx  = overflow;
    // A tick and a done in the same cycle cancel out.
    if (tick && !done) begin
      if (debt != 4'(DEBT_MAX)) debt_nx = debt + 4'd1;
    end else if (done && !tick && debt != 4'd0) begin
      debt_nx = debt - 4'd1;
    end
    if (tick && debt == 4'(DEBT_MAX)) ovf_nx = 1'b1;
  end

  // ------------------------------------------------------------------- FSM
  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    forced_nx = forced;
    case (state)
      S_IDLE: begin
        if (debt >= 4'(URGENT_LEVEL)) begin
          state_nx  = S_DRAIN;
          phase_nx  = '0;
          forced_nx = 1'b1;
        end else if (debt != 4'd0 && idle_cnt == IW'(IDLE_MAX) && !rise) begin
          state_nx  = S_REF;
          phase_nx  = '0;
          forced_nx = 1'b0;
        end
      end
      // Three slots let up to three already-pending channel accesses finish.
      S_DRAIN: begin
        if (phase == IW'(IDLE_MAX - 1)) begin
          state_nx = S_REF;
          phase_nx = '0;
        end else begin
          phase_nx = phase + 1'b1;
        end
      end
      S_REF: begin
        if (done) begin
          phase_nx = '0;
          // A forced batch keeps going back-to-back until debt is paid off.
          if (!(forced && debt_nx != 4'd0)) begin
            state_nx  = S_IDLE;
            forced_nx = 1'b0;
          end
        end else begin
          phase_nx = phase + 1'b1;
        end
      end
      default: begin
        state_nx  = S_IDLE;
        phase_nx  = '0;
        forced_nx = 1'b0;
      end
    endcase
  end

  // mask/refresh are decoded from the next state so they are registered and
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state    <= S_IDLE;
      phase    <= '0;
      forced   <= 1'b0;
      debt     <= 4'd0;
      overflow <= 1'b0;
      mask     <= 1'b0;
      refresh  <= 1'b0;
    end else begin
      state    <= state_nx;
      phase    <= phase_nx;
      forced   <= forced_nx;
      debt     <= debt_nx;
      overflow <= ovf_nx;
      mask     <= (state_nx != S_IDLE);
      refresh  <= (state_nx == S_REF);
    end
  end

  // ------------------------------------------------------------------ gate
  // While masked, an output can only stay high or fall; a rising input is
  // deferred until mask drops, then passes through combinationally.
  always_comb begin
    rd_out = '0;
    wr_out = '0;
    if (init_n) begin
      rd_out = mask ? (rd_hold & rd_in) : rd_in;
      wr_out = mask ? (wr_hold & wr_in) : wr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      rd_hold <= '0;
      wr_hold <= '0;
    end else begin
      rd_hold <= rd_out;
      wr_hold <= wr_out;
    end
  end

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Directed bench for sdram_refresh_sched. Three instances share clock and
// reset: A (defaults), C (REFI_CYCLES=40) and O (REFI_CYCLES=4, SLOT_CYCLES=3).
// cyc counts clock edges since reset release; checks sample 1-2 ns after edge.
module tb_sdram_refresh_sched;

  logic       clk = 1'b0;
  logic       init_n;
  logic [2:0] rd_a, wr_a, rd_out_a, wr_out_a;
  logic       refresh_a, mask_a, overflow_a;
  logic [3:0] debt_a;
  logic [2:0] rd_c, wr_c, rd_out_c, wr_out_c;
  logic       refresh_c, mask_c, overflow_c;
  logic [3:0] debt_c;
  logic [2:0] rd_o, wr_o, rd_out_o, wr_out_o;
  logic       refresh_o, mask_o, overflow_o;
  logic [3:0] debt_o;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  en_a, en_c, en_o;

  always #5 clk = ~clk;

  sdram_refresh_sched u_a (
    .clk(clk), .init_n(init_n), .rd_in(rd_a), .wr_in(wr_a),
    .rd_out(rd_out_a), .wr_out(wr_out_a), .refresh(refresh_a),
    .mask(mask_a), .debt(debt_a), .overflow(overflow_a));

  sdram_refresh_sched #(.REFI_CYCLES(40)) u_c (
    .clk(clk), .init_n(init_n), .rd_in(rd_c), .wr_in(wr_c),
    .rd_out(rd_out_c), .wr_out(wr_out_c), .refresh(refresh_c),
    .mask(mask_c), .debt(debt_c), .overflow(overflow_c));

  sdram_refresh_sched #(.REFI_CYCLES(4), .SLOT_CYCLES(3), .DEBT_MAX(8),
                        .URGENT_LEVEL(6)) u_o (
    .clk(clk), .init_n(init_n), .rd_in(rd_o), .wr_in(wr_o),
    .rd_out(rd_out_o), .wr_out(wr_out_o), .refresh(refresh_o),
    .mask(mask_o), .debt(debt_o), .overflow(overflow_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; then apply the traffic pattern for the new cycle.
  task automatic step;
    @(posedge clk); #1;
    cyc++;
    if (en_a) rd_a[0] = (cyc % 10) < 5;
    if (en_o) rd_o[0] = (cyc % 4) < 2;
    if (en_c) begin
      if (cyc == 20 || cyc == 40)      rd_c[0] = 1'b0;
      else if (cyc == 30 || cyc == 46) rd_c[0] = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset(input bit ea, input bit ec, input bit eo);
    en_a = 0; en_c = 0; en_o = 0;
    init_n = 1'b0;
    rd_a = '0; wr_a = '0; rd_c = '0; wr_c = '0; rd_o = '0; wr_o = '0;
    step; step;
    init_n = 1'b1;
    cyc = 0;
    en_a = ea; en_c = ec; en_o = eo;
    rd_a[0] = ea; rd_c[0] = ec; rd_o[0] = eo;
    #1;
  endtask

  int  ref_cnt, mask_cnt, pre_ref;
  int  max_debt_o;
  bit  o_zero_seen;

  initial begin
    // ---- reset state, outputs forced low while init_n=0
    init_n = 1'b0;
    rd_a = 3'b111; wr_a = 3'b111;
    rd_c = '0; wr_c = '0; rd_o = '0; wr_o = '0;
    en_a = 0; en_c = 0; en_o = 0;
    step; step;
    chk("rst_rd_out", rd_out_a, 0);
    chk("rst_wr_out", wr_out_a, 0);
    chk("rst_refresh", refresh_a, 0);
    chk("rst_mask", mask_a, 0);
    chk("rst_debt", debt_a, 0);
    chk("rst_overflow", overflow_a, 0);

    // ---- phase 1: no traffic, single opportunistic refresh
    do_reset(0, 0, 0);
    ref_cnt = 0;
    for (int i = 1; i <= 672; i++) begin
      step;
      if (cyc >= 664) ref_cnt += int'(refresh_a);
      if (cyc == 662) chk("p1_debt_pre_tick", debt_a, 0);
      if (cyc == 663) begin
        chk("p1_debt_tick", debt_a, 1);
        chk("p1_refresh_pre", refresh_a, 0);
      end
      if (cyc == 664) begin
        chk("p1_refresh_start", refresh_a, 1);
        chk("p1_mask_start", mask_a, 1);
      end
      if (cyc == 672) begin
        chk("p1_debt_done", debt_a, 0);
        chk("p1_mask_end", mask_a, 0);
        chk("p1_refresh_end", refresh_a, 0);
      end
    end
    chk("p1_refresh_cycles", ref_cnt, 8);

    // ---- phase 2: A forced batch + gate, C tick/done coincidence, O overflow
    do_reset(1, 1, 1);
    ref_cnt = 0; mask_cnt = 0; pre_ref = 0;
    max_debt_o = 0; o_zero_seen = 0;
    for (int i = 1; i <= 4060; i++) begin
      step;
      // instance A
      if (cyc <= 3978) pre_ref += int'(refresh_a);
      if (cyc >= 3979 && cyc <= 4050) begin
        ref_cnt  += int'(refresh_a);
        mask_cnt += int'(mask_a);
      end
      if (cyc == 3900) wr_a[1] = 1'b1;
      if (cyc == 3977) chk("a_debt5", debt_a, 5);
      if (cyc == 3978) begin
        chk("a_debt6", debt_a, 6);
        chk("a_no_opp_ref", pre_ref, 0);
        chk("a_mask_pre", mask_a, 0);
      end
      if (cyc == 3979) begin
        chk("a_drain_mask", mask_a, 1);
        chk("a_drain_norefresh", refresh_a, 0);
      end
      if (cyc == 3989) chk("a_wr_held_high", wr_out_a[1], 1);
      if (cyc == 3990) begin
        wr_a[1] = 1'b0; #1;
        chk("a_wr_fall_pass", wr_out_a[1], 0);
      end
      if (cyc == 4002) chk("a_drain_last", refresh_a, 0);
      if (cyc == 4003) chk("a_ref_first", refresh_a, 1);
      if (cyc == 4020) begin
        wr_a[1] = 1'b1; #1;
        chk("a_wr_rise_blocked", wr_out_a[1], 0);
      end
      if (cyc == 4050) begin
        chk("a_rd_deferred", rd_out_a[0], 0);
        chk("a_wr_deferred", wr_out_a[1], 0);
      end
      if (cyc == 4051) begin
        chk("a_mask_fall", mask_a, 0);
        chk("a_debt_paid", debt_a, 0);
        chk("a_rd_release", rd_out_a[0], 1);
        chk("a_wr_release", wr_out_a[1], 1);
      end
      // instance C: opportunistic REF whose done lands on the tick at 80
      if (cyc == 71) chk("c_no_ref_yet", refresh_c, 0);
      if (cyc == 72) begin
        chk("c_ref_start", refresh_c, 1);
        chk("c_mask_start", mask_c, 1);
      end
      if (cyc == 79) chk("c_debt_before", debt_c, 1);
      if (cyc == 80) begin
        chk("c_debt_tick_done", debt_c, 1);
        chk("c_ref_end", refresh_c, 0);
      end
      if (cyc == 81) chk("c_ref_again", refresh_c, 1);
      if (cyc == 89) chk("c_debt_zero", debt_c, 0);
      // instance O: saturation and sticky overflow
      if (int'(debt_o) > max_debt_o) max_debt_o = int'(debt_o);
      if (cyc == 32) chk("o_debt_sat", debt_o, 8);
      if (cyc == 35) chk("o_ovf_clear", overflow_o, 0);
      if (cyc == 36) begin
        chk("o_ovf_set", overflow_o, 1);
        chk("o_debt_hold", debt_o, 8);
      end
      if (!o_zero_seen && cyc > 36 && debt_o == 4'd0) begin
        o_zero_seen = 1;
        chk("o_ovf_sticky", overflow_o, 1);
        chk("o_mask_after_drain", mask_o, 0);
      end
    end
    chk("a_batch_refresh", ref_cnt, 48);
    chk("a_batch_mask", mask_cnt, 72);
    chk("o_drained", o_zero_seen, 1);
    chk("o_debt_max", max_debt_o, 8);

    // ---- phase 3: reset during the third REF cycle
    do_reset(0, 0, 1);
    for (int i = 1; i <= 666; i++) step;
    chk("r_in_ref", refresh_a, 1);
    chk("r_ovf_before", overflow_o, 1);
    init_n = 1'b0;
    rd_a = 3'b111; wr_a = 3'b111;
    #1;
    chk("r_rd_out_low", rd_out_a, 0);
    chk("r_wr_out_low", wr_out_a, 0);
    step;
    chk("r_refresh", refresh_a, 0);
    chk("r_mask", mask_a, 0);
    chk("r_debt", debt_a, 0);
    chk("r_overflow", overflow_o, 0);
    chk("r_rd_out_held", rd_out_a, 0);
    init_n = 1'b1;
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
